// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (colour lookup, overlay and sprite stages).
interface vga_timing_if;
  logic       iEN;
  logic       oHS;
  logic       oVS;
  logic       oBLANK_n;
  logic [9:0] oX;
  logic [9:0] oY;
  logic       oLINE_END;
  logic       oFRAME_START;
  logic [7:0] oFRAME;

  modport master (
    input  iEN,
    output oHS, oVS, oBLANK_n, oX, oY, oLINE_END, oFRAME_START, oFRAME
  );

  modport slave (
    output iEN,
    input  oHS, oVS, oBLANK_n, oX, oY, oLINE_END, oFRAME_START, oFRAME
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: h/v counters plus registered sync,
// blank, coordinate and frame-marker decodes with a fixed one-clock latency.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Decode bounds kept 11 bits wide so a sync end of 1024 still compares correctly.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] H_ACT_M1 = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] h_ext, v_ext;
  logic        h_last, v_last;
  logic        h_act, v_act;
  logic        hs_act, vs_act;
  logic        line_end, frame_start;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  always_comb begin
    h_last      = (h_ext == H_LAST);
    v_last      = (v_ext == V_LAST);
    h_act       = (h_ext < H_ACT);
    v_act       = (v_ext < V_ACT);
    hs_act      = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_act      = (v_ext >= VS_BEG) && (v_ext < VS_END);
    line_end    = (h_ext == H_ACT_M1) && v_act;
    frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt            <= '0;
      v_cnt            <= '0;
      vga.oHS          <= ~HS_POL;
      vga.oVS          <= ~VS_POL;
      vga.oBLANK_n     <= 1'b0;
      vga.oX           <= '0;
      vga.oY           <= '0;
      vga.oLINE_END    <= 1'b0;
      vga.oFRAME_START <= 1'b0;
      vga.oFRAME       <= '0;
    end else if (vga.iEN) begin
      h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
      if (h_last)
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;

      vga.oHS          <= hs_act ? HS_POL : ~HS_POL;
      vga.oVS          <= vs_act ? VS_POL : ~VS_POL;
      vga.oBLANK_n     <= h_act && v_act;
      vga.oX           <= (h_act && v_act) ? h_cnt : 10'd0;
      vga.oY           <= (h_act && v_act) ? v_cnt : 10'd0;
      vga.oLINE_END    <= line_end;
      vga.oFRAME_START <= frame_start;
      // Bump alongside the pulse so the new frame number is visible with it.
      if (frame_start)
        vga.oFRAME <= vga.oFRAME + 8'd1;
    end else begin
      // Held: levels freeze, pulses drop so they are not seen twice.
      vga.oLINE_END    <= 1'b0;
      vga.oFRAME_START <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus two reduced-raster instances
// (one with positive sync polarity) checked cycle by cycle against closed-form timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  int n_chk  = 0;
  int n_pass = 0;
  int cur_k  = 0;

  always #5 clk = ~clk;

  vga_timing_if if_def ();
  vga_timing_if if_sml ();
  vga_timing_if if_pol ();

  assign if_def.iEN = en;
  assign if_sml.iEN = en;
  assign if_pol.iEN = en;

  vga_timing_gen dut_def (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .vga      (if_def)
  );

  // Reduced raster: 15 clocks/line, 8 lines/frame, 120 clocks/frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_sml (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .vga      (if_sml)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_pol (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .vga      (if_pol)
  );

  function automatic logic [39:0] pack(logic [7:0] fr, logic bl, logic hs, logic vs,
                                       logic le, logic fs, logic [9:0] x, logic [9:0] y);
    return {7'd0, fr, bl, hs, vs, le, fs, x, y};
  endfunction

  // Expected outputs k clocks after the first post-reset edge (k=0 is pixel 0,0).
  function automatic logic [39:0] exp_vec(int k, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb,
                                          bit pol, bit held);
    int ht, vt, ft, p, h, v;
    bit bl, hsa, vsa, le, fs;
    logic [7:0] fr;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    ft  = ht * vt;
    p   = k % ft;
    h   = p % ht;
    v   = p / ht;
    bl  = (h < ha) && (v < va);
    hsa = (h >= ha + hf) && (h < ha + hf + hsw);
    vsa = (v >= va + vf) && (v < va + vf + vsw);
    le  = (h == ha - 1) && (v < va) && !held;
    fs  = (p == 0) && !held;
    fr  = 8'(((k / ft) + 1) % 256);
    return pack(fr, bl, pol ? hsa : !hsa, pol ? vsa : !vsa, le, fs,
                bl ? 10'(h) : 10'd0, bl ? 10'(v) : 10'd0);
  endfunction

  task automatic chk(string tag, logic [39:0] got, logic [39:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d got=%h exp=%h", tag, cur_k, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(bit held);
    chk("def", pack(if_def.oFRAME, if_def.oBLANK_n, if_def.oHS, if_def.oVS,
                    if_def.oLINE_END, if_def.oFRAME_START, if_def.oX, if_def.oY),
        exp_vec(cur_k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, held));
    chk("sml", pack(if_sml.oFRAME, if_sml.oBLANK_n, if_sml.oHS, if_sml.oVS,
                    if_sml.oLINE_END, if_sml.oFRAME_START, if_sml.oX, if_sml.oY),
        exp_vec(cur_k, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, held));
    chk("pol", pack(if_pol.oFRAME, if_pol.oBLANK_n, if_pol.oHS, if_pol.oVS,
                    if_pol.oLINE_END, if_pol.oFRAME_START, if_pol.oX, if_pol.oY),
        exp_vec(cur_k, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, held));
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_def"}, pack(if_def.oFRAME, if_def.oBLANK_n, if_def.oHS, if_def.oVS,
                            if_def.oLINE_END, if_def.oFRAME_START, if_def.oX, if_def.oY),
        pack(8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0));
    chk({tag, "_sml"}, pack(if_sml.oFRAME, if_sml.oBLANK_n, if_sml.oHS, if_sml.oVS,
                            if_sml.oLINE_END, if_sml.oFRAME_START, if_sml.oX, if_sml.oY),
        pack(8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0));
    chk({tag, "_pol"}, pack(if_pol.oFRAME, if_pol.oBLANK_n, if_pol.oHS, if_pol.oVS,
                            if_pol.oLINE_END, if_pol.oFRAME_START, if_pol.oX, if_pol.oY),
        pack(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0));
  endtask

  // Drop enable right after observing cur_k; outputs must stay at cur_k with pulses low.
  task automatic hold(int n);
    en = 1'b0;
    repeat (n) begin
      tick();
      check_all(1'b1);
    end
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) begin
      tick();
      chk_rst("rst");
    end
    rst_n = 1'b1;

    // 257 reduced frames plus margin; default instance covers ~38 lines meanwhile.
    for (int k = 0; k < 257 * 120 + 30; k++) begin
      tick();
      cur_k = k;
      check_all(1'b0);
      if (k == 100 || k == 240 || k == 639) hold(50);
    end

    // Mid-frame reset: takes effect immediately, no clock needed.
    rst_n = 1'b0;
    #1;
    chk_rst("mid_rst_async");
    repeat (3) begin
      tick();
      chk_rst("mid_rst");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 250; k++) begin
      tick();
      cur_k = k;
      check_all(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
